// File: rtl/ball_renderer.sv
// Three-stage pixel pipeline that paints a filled circle over a flat background.
// Ball geometry is latched once per frame on the vsync falling edge.
module ball_renderer #(
  parameter logic [3:0] BG_R   = 4'h0,
  parameter logic [3:0] BG_G   = 4'h0,
  parameter logic [3:0] BG_B   = 4'h8,
  parameter logic [9:0] INIT_X = 10'd320,
  parameter logic [9:0] INIT_Y = 10'd240,
  parameter logic [9:0] INIT_S = 10'd16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       vde,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       de_out,
  output logic       hs_out,
  output logic       vs_out
);

  logic        vs_prev_q;
  logic [9:0]  sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;
  logic [9:0]  ss_q, ss_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        frame_start;

  logic [10:0] dx1_q, dx1_d;
  logic [10:0] dy1_q, dy1_d;
  logic [9:0]  ss1_q;
  logic [1:0]  pal1_q;
  logic        de1_q, hs1_q, vs1_q;

  logic [21:0] dxsq2_q, dxsq2_d;
  logic [21:0] dysq2_q, dysq2_d;
  logic [19:0] sssq2_q, sssq2_d;
  logic [1:0]  pal2_q;
  logic        de2_q, hs2_q, vs2_q;

  logic [21:0] dx_ext, dy_ext;
  logic [22:0] dist_sq;
  logic        hit;
  logic [11:0] pal_rgb;
  logic [11:0] rgb_q, rgb_d;
  logic        de_q, hs_q, vs_q;

  always_comb begin
    frame_start = vs_prev_q & ~vsync;
    sx_d   = sx_q;
    sy_d   = sy_q;
    ss_d   = ss_q;
    fcnt_d = fcnt_q;
    if (frame_start) begin
      sx_d   = BallX;
      sy_d   = BallY;
      ss_d   = BallS;
      fcnt_d = fcnt_q + 8'd1;
    end

    dx1_d = {1'b0, DrawX} - {1'b0, sx_q};
    dy1_d = {1'b0, DrawY} - {1'b0, sy_q};

    // Low 22 bits of the product are sign-agnostic once operands are sign-extended
    dx_ext  = {{11{dx1_q[10]}}, dx1_q};
    dy_ext  = {{11{dy1_q[10]}}, dy1_q};
    dxsq2_d = dx_ext * dx_ext;
    dysq2_d = dy_ext * dy_ext;
    sssq2_d = {10'd0, ss1_q} * {10'd0, ss1_q};

    dist_sq = {1'b0, dxsq2_q} + {1'b0, dysq2_q};
    hit     = dist_sq <= {3'd0, sssq2_q};

    unique case (pal2_q)
      2'd0:    pal_rgb = 12'hF70;
      2'd1:    pal_rgb = 12'hFF0;
      2'd2:    pal_rgb = 12'h0FF;
      default: pal_rgb = 12'hF0F;
    endcase

    if (!de2_q)   rgb_d = 12'h000;
    else if (hit) rgb_d = pal_rgb;
    else          rgb_d = {BG_R, BG_G, BG_B};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      vs_prev_q <= 1'b1;
      sx_q      <= INIT_X;
      sy_q      <= INIT_Y;
      ss_q      <= INIT_S;
      fcnt_q    <= 8'd0;
      dx1_q     <= '0;
      dy1_q     <= '0;
      ss1_q     <= '0;
      pal1_q    <= '0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b1;
      dxsq2_q   <= '0;
      dysq2_q   <= '0;
      sssq2_q   <= '0;
      pal2_q    <= '0;
      de2_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b1;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b1;
    end else begin
      vs_prev_q <= vsync;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ss_q      <= ss_d;
      fcnt_q    <= fcnt_d;
      dx1_q     <= dx1_d;
      dy1_q     <= dy1_d;
      ss1_q     <= ss_q;
      pal1_q    <= fcnt_q[6:5];
      de1_q     <= vde;
      hs1_q     <= hsync;
      vs1_q     <= vsync;
      dxsq2_q   <= dxsq2_d;
      dysq2_q   <= dysq2_d;
      sssq2_q   <= sssq2_d;
      pal2_q    <= pal1_q;
      de2_q     <= de1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      rgb_q     <= rgb_d;
      de_q      <= de2_q;
      hs_q      <= hs2_q;
      vs_q      <= vs2_q;
    end
  end

  assign Red    = rgb_q[11:8];
  assign Green  = rgb_q[7:4];
  assign Blue   = rgb_q[3:0];
  assign de_out = de_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: geometry, palette, sync delay and reset flush.
module tb_ball_renderer;

  logic       clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       vde, hsync, vsync;
  logic [9:0] BallX, BallY, BallS;
  logic [3:0] Red, Green, Blue;
  logic       de_out, hs_out, vs_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [11:0] C_P0 = 12'hF70;
  localparam logic [11:0] C_P1 = 12'hFF0;
  localparam logic [11:0] C_P2 = 12'h0FF;
  localparam logic [11:0] C_P3 = 12'hF0F;
  localparam logic [11:0] C_BG = 12'h008;

  ball_renderer dut (
    .clk(clk), .Reset(Reset),
    .DrawX(DrawX), .DrawY(DrawY),
    .vde(vde), .hsync(hsync), .vsync(vsync),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .Red(Red), .Green(Green), .Blue(Blue),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  wire [11:0] rgb = {Red, Green, Blue};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and wait for it to reach the outputs
  task automatic px(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    repeat (3) step();
  endtask

  task automatic vs_edge();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    vde = 1'b1; hsync = 1'b1; vsync = 1'b1;
    DrawX = 10'd320; DrawY = 10'd240;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd16;
    repeat (3) step();
    n_checks++;
    if (rgb !== 12'h000) begin
      n_fail++; $display("FAIL reset_rgb got %h want 000", rgb);
    end
    n_checks++;
    if (de_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_de got %b want 0", de_out);
    end
    n_checks++;
    if (hs_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs got %b want 0", hs_out);
    end
    n_checks++;
    if (vs_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_vs got %b want 1", vs_out);
    end
    Reset = 1'b0;
  endtask

  task automatic test_center();
    px(10'd320, 10'd240);
    n_checks++;
    if (rgb !== C_P0) begin
      n_fail++; $display("FAIL center_rgb got %h want %h", rgb, C_P0);
    end
    n_checks++;
    if (de_out !== 1'b1) begin
      n_fail++; $display("FAIL center_de got %b want 1", de_out);
    end
  endtask

  task automatic test_edges();
    logic [9:0]  xs [6] = '{10'd336, 10'd337, 10'd304, 10'd303, 10'd320, 10'd320};
    logic [9:0]  ys [6] = '{10'd240, 10'd240, 10'd240, 10'd240, 10'd224, 10'd223};
    logic [11:0] ex [6] = '{C_P0, C_BG, C_P0, C_BG, C_P0, C_BG};
    for (int i = 0; i < 6; i++) begin
      px(xs[i], ys[i]);
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++;
        $display("FAIL edge_%0d (%0d,%0d) got %h want %h", i, xs[i], ys[i], rgb, ex[i]);
      end
    end
  endtask

  task automatic test_shadow();
    BallX = 10'd100;
    repeat (5) step();
    px(10'd100, 10'd240);
    n_checks++;
    if (rgb !== C_BG) begin
      n_fail++; $display("FAIL shadow_hold got %h want %h", rgb, C_BG);
    end
    vs_edge();
    px(10'd100, 10'd240);
    n_checks++;
    if (rgb !== C_P0) begin
      n_fail++; $display("FAIL shadow_load got %h want %h", rgb, C_P0);
    end
    px(10'd320, 10'd240);
    n_checks++;
    if (rgb !== C_BG) begin
      n_fail++; $display("FAIL shadow_old got %h want %h", rgb, C_BG);
    end
  endtask

  // One edge already taken; totals reach 32, 64, 96 and 256
  task automatic test_fcnt();
    int          add [4] = '{31, 32, 32, 160};
    logic [11:0] ex  [4] = '{C_P1, C_P2, C_P3, C_P0};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < add[k]; j++) vs_edge();
      px(10'd100, 10'd240);
      n_checks++;
      if (rgb !== ex[k]) begin
        n_fail++; $display("FAIL fcnt_%0d got %h want %h", k, rgb, ex[k]);
      end
    end
  endtask

  task automatic test_radius0();
    BallS = 10'd0;
    vs_edge();
    px(10'd100, 10'd240);
    n_checks++;
    if (rgb !== C_P0) begin
      n_fail++; $display("FAIL r0_center got %h want %h", rgb, C_P0);
    end
    px(10'd101, 10'd240);
    n_checks++;
    if (rgb !== C_BG) begin
      n_fail++; $display("FAIL r0_right got %h want %h", rgb, C_BG);
    end
    px(10'd100, 10'd239);
    n_checks++;
    if (rgb !== C_BG) begin
      n_fail++; $display("FAIL r0_up got %h want %h", rgb, C_BG);
    end
  endtask

  task automatic test_offscreen();
    logic [9:0]  xs [4] = '{10'd0, 10'd639, 10'd614, 10'd613};
    logic [11:0] ex [4] = '{C_BG, C_P0, C_P0, C_BG};
    BallX = 10'd630; BallY = 10'd240; BallS = 10'd16;
    vs_edge();
    for (int i = 0; i < 4; i++) begin
      px(xs[i], 10'd240);
      n_checks++;
      if (rgb !== ex[i]) begin
        n_fail++; $display("FAIL offscr_%0d got %h want %h", i, rgb, ex[i]);
      end
    end
  endtask

  task automatic test_negative();
    BallX = 10'd1023; BallY = 10'd1023; BallS = 10'd1023;
    vs_edge();
    px(10'd0, 10'd1023);
    n_checks++;
    if (rgb !== C_P0) begin
      n_fail++; $display("FAIL neg_edge got %h want %h", rgb, C_P0);
    end
    px(10'd0, 10'd1022);
    n_checks++;
    if (rgb !== C_BG) begin
      n_fail++; $display("FAIL neg_out got %h want %h", rgb, C_BG);
    end
  endtask

  task automatic test_vde0_sync();
    logic hs_pat [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1};
    logic vs_pat [12] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1};
    vde = 1'b0;
    DrawX = 10'd0; DrawY = 10'd1023;
    for (int i = 0; i < 12; i++) begin
      hsync = hs_pat[i];
      vsync = vs_pat[i];
      step();
      if (i >= 2) begin
        n_checks++;
        if (hs_out !== hs_pat[i-2] || vs_out !== vs_pat[i-2]) begin
          n_fail++;
          $display("FAIL sync_%0d got hs=%b vs=%b want hs=%b vs=%b",
                   i, hs_out, vs_out, hs_pat[i-2], vs_pat[i-2]);
        end
        n_checks++;
        if (rgb !== 12'h000 || de_out !== 1'b0) begin
          n_fail++; $display("FAIL vde0_%0d got rgb=%h de=%b want 000/0", i, rgb, de_out);
        end
      end
    end
    hsync = 1'b1; vsync = 1'b1; vde = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    logic [9:0]  xs [40];
    logic        rs [40];
    logic [11:0] exp_rgb;
    logic        exp_de;
    int          d;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd16;
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    DrawY = 10'd240;
    for (int i = 0; i < 40; i++) begin
      xs[i] = 10'(300 + i);
      rs[i] = (i >= 12 && i <= 14);
    end
    for (int i = 0; i < 40; i++) begin
      DrawX = xs[i];
      Reset = rs[i];
      step();
      if (i >= 2) begin
        exp_de = 1'b1;
        for (int k = i - 2; k <= i; k++) if (rs[k]) exp_de = 1'b0;
        d = int'(xs[i-2]) - 320;
        if (!exp_de)             exp_rgb = 12'h000;
        else if (d * d <= 256)   exp_rgb = C_P0;
        else                     exp_rgb = C_BG;
        n_checks++;
        if (rgb !== exp_rgb || de_out !== exp_de) begin
          n_fail++;
          $display("FAIL rstmid_%0d got rgb=%h de=%b want %h/%b",
                   i, rgb, de_out, exp_rgb, exp_de);
        end
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_center();
    test_edges();
    test_shadow();
    test_fcnt();
    test_radius0();
    test_offscreen();
    test_negative();
    test_vde0_sync();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
